// File: rtl/fetch_pc_gen_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Holds the reset fetch address and the fetch FSM state encodings.
// Imported by the fetch interface and the fetch PC generator.
package fetch_pc_gen_pkg;

  // Address of the first instruction fetched after reset.
  localparam logic [31:0] FETCH_RESET_PC = 32'h1c00_0000;

  // Fetch FSM encodings (plain constants for legacy tool compatibility).
  localparam logic [1:0] FS_IDLE = 2'd0;
  localparam logic [1:0] FS_REQ  = 2'd1;
  localparam logic [1:0] FS_WAIT = 2'd2;

  // Word-align an address; the low two bits of any fetch address are zero.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// SRAM-like instruction port: one request/accept pair plus one response strobe.
// Latency: set by the memory; at least one cycle from accept to response.
// Backpressure: the memory stalls a request by holding inst_addr_ok low.
interface fetch_pc_gen_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  // Fetch side drives the request, memory side drives accept and response.
  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: one outstanding instruction request, one output slot to decode.
// Latency: accept in cycle n, response in n+1 gives a valid slot in n+2 (1 instr / 2 cycles).
// Backpressure: no request is issued while the slot is full and decode is not taking it.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   br_taken,
  input  logic [31:0]            br_target,
  fetch_pc_gen_if.master         imem,
  input  logic                   ds_allowin,
  output logic                   fs_valid,
  output logic [31:0]            fs_pc,
  output logic [31:0]            fs_inst
);

  logic [1:0]  state_q,    state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q,   req_pc_d;
  logic        cancel_q,   cancel_d;
  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q,    fs_pc_d;
  logic [31:0] fs_inst_q,  fs_inst_d;

  logic        req;
  logic        accept;
  logic        slot_load;

  // A request is only raised when the slot will be free by the time data returns;
  // a redirect suppresses it so the wrong-path address is never accepted.
  always_comb begin
    req       = (state_q == FS_REQ) && (!fs_valid_q || ds_allowin) && !br_taken;
    accept    = req && imem.inst_addr_ok;
    slot_load = (state_q == FS_WAIT) && imem.inst_data_ok && !cancel_q && !br_taken;
  end

  assign imem.inst_req  = req;
  assign imem.inst_addr = word_align(fetch_pc_q);
  assign fs_valid       = fs_valid_q;
  assign fs_pc          = fs_pc_q;
  assign fs_inst        = fs_inst_q;

  // Next-state logic for the FSM, fetch/request PCs, cancel flag and output slot.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    cancel_d   = cancel_q;
    fs_valid_d = fs_valid_q;
    fs_pc_d    = fs_pc_q;
    fs_inst_d  = fs_inst_q;

    case (state_q)
      FS_IDLE: state_d = FS_REQ;
      FS_REQ: begin
        if (accept) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (imem.inst_data_ok) begin
          // The outstanding response retires; a cancelled one is simply dropped.
          state_d  = FS_REQ;
          cancel_d = 1'b0;
        end
      end
      default: state_d = FS_IDLE;
    endcase

    // Decode taking the slot empties it unless a new instruction lands the same cycle.
    if (fs_valid_q && ds_allowin) begin
      fs_valid_d = 1'b0;
    end

    if (slot_load) begin
      fs_valid_d = 1'b1;
      fs_pc_d    = req_pc_q;
      fs_inst_d  = imem.inst_rdata;
    end

    // Redirect: restart at the target, flush the slot, and mark a still-pending
    // response as stale. A newer redirect only replaces the target.
    if (br_taken && (state_q != FS_IDLE)) begin
      fetch_pc_d = word_align(br_target);
      fs_valid_d = 1'b0;
      if ((state_q == FS_WAIT) && !imem.inst_data_ok) begin
        cancel_d = 1'b1;
      end
    end
  end

  // State registers; reset clears everything and restarts fetch at RESET_PC.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= FS_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'd0;
      cancel_q   <= 1'b0;
      fs_valid_q <= 1'b0;
      fs_pc_q    <= 32'd0;
      fs_inst_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      cancel_q   <= cancel_d;
      fs_valid_q <= fs_valid_d;
      fs_pc_q    <= fs_pc_d;
      fs_inst_q  <= fs_inst_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: the bench plays the instruction memory cycle by cycle.
// Inputs change 1ns after each rising edge; outputs are sampled 1ns later.
// Expected values are hand-computed constants.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        resetn;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ds_allowin;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_pc_gen_if ifc ();

  fetch_pc_gen dut (
    .clk        (clk),
    .resetn     (resetn),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem       (ifc),
    .ds_allowin (ds_allowin),
    .fs_valid   (fs_valid),
    .fs_pc      (fs_pc),
    .fs_inst    (fs_inst)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle's inputs and let combinational outputs settle.
  task automatic drive(input logic br, input logic [31:0] tgt, input logic aok,
                       input logic dok, input logic [31:0] rd, input logic allow);
    br_taken         = br;
    br_target        = tgt;
    ifc.inst_addr_ok = aok;
    ifc.inst_data_ok = dok;
    ifc.inst_rdata   = rd;
    ds_allowin       = allow;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("rst_req",   {31'd0, ifc.inst_req}, 32'd0);
    check("rst_valid", {31'd0, fs_valid},     32'd0);
    check("rst_pc",    fs_pc,                 32'd0);
    check("rst_inst",  fs_inst,               32'd0);
    tick;
    tick;
    resetn = 1'b1;
    drive(0, 0, 0, 0, 0, 1);
    check("idle_req", {31'd0, ifc.inst_req}, 32'd0);
    tick;

    // Sequential fetch, best-case memory
    drive(0, 0, 1, 0, 0, 1);
    check("seq_req0",  {31'd0, ifc.inst_req}, 32'd1);
    check("seq_addr0", ifc.inst_addr, 32'h1c00_0000);
    tick;
    drive(0, 0, 0, 1, 32'hAAAA_0000, 1);
    check("wait_req", {31'd0, ifc.inst_req}, 32'd0);
    tick;
    drive(0, 0, 1, 0, 0, 1);
    check("seq_valid0", {31'd0, fs_valid}, 32'd1);
    check("seq_pc0",    fs_pc,   32'h1c00_0000);
    check("seq_inst0",  fs_inst, 32'hAAAA_0000);
    check("seq_addr1",  ifc.inst_addr, 32'h1c00_0004);
    check("seq_req1",   {31'd0, ifc.inst_req}, 32'd1);
    tick;
    drive(0, 0, 0, 1, 32'hBBBB_0004, 0);
    tick;

    // Decode stall with a full slot
    drive(0, 0, 1, 0, 0, 0);
    check("stall_req0", {31'd0, ifc.inst_req}, 32'd0);
    check("stall_pc",   fs_pc, 32'h1c00_0004);
    tick;
    drive(0, 0, 1, 0, 0, 0);
    check("stall_req1",  {31'd0, ifc.inst_req}, 32'd0);
    check("stall_valid", {31'd0, fs_valid}, 32'd1);
    check("stall_inst",  fs_inst, 32'hBBBB_0004);
    drive(0, 0, 1, 0, 0, 1);
    check("unstall_req",  {31'd0, ifc.inst_req}, 32'd1);
    check("unstall_addr", ifc.inst_addr, 32'h1c00_0008);
    tick;
    check("consume_valid", {31'd0, fs_valid}, 32'd0);

    // Redirect while waiting; the late response must be dropped
    drive(1, 32'h1c00_0103, 0, 0, 0, 1);
    check("br_req", {31'd0, ifc.inst_req}, 32'd0);
    tick;
    check("br_flush", {31'd0, fs_valid}, 32'd0);
    drive(0, 0, 0, 0, 0, 1);
    check("br_wait_req", {31'd0, ifc.inst_req}, 32'd0);
    tick;
    drive(0, 0, 0, 0, 0, 1);
    tick;
    drive(0, 0, 0, 1, 32'hDEAD_BEEF, 1);
    tick;
    check("cancel_drop", {31'd0, fs_valid}, 32'd0);
    drive(0, 0, 1, 0, 0, 1);
    check("br_tgt_req",  {31'd0, ifc.inst_req}, 32'd1);
    check("br_tgt_addr", ifc.inst_addr, 32'h1c00_0100);
    tick;

    // Redirect in REQ with a full, stalled slot
    drive(0, 0, 0, 1, 32'hCCCC_0100, 0);
    tick;
    drive(0, 0, 1, 0, 0, 0);
    check("full_pc", fs_pc, 32'h1c00_0100);
    drive(1, 32'h2000_0010, 1, 0, 0, 0);
    tick;
    check("req_br_flush", {31'd0, fs_valid}, 32'd0);
    drive(0, 0, 1, 0, 0, 1);
    check("req_br_req",  {31'd0, ifc.inst_req}, 32'd1);
    check("req_br_addr", ifc.inst_addr, 32'h2000_0010);
    tick;

    // Redirect coincident with the response: no load, no cancel
    drive(1, 32'h3000_0000, 0, 1, 32'hEEEE_EEEE, 1);
    tick;
    check("coin_valid", {31'd0, fs_valid}, 32'd0);
    drive(0, 0, 1, 0, 0, 1);
    check("coin_addr", ifc.inst_addr, 32'h3000_0000);
    tick;
    drive(0, 0, 0, 1, 32'hFFFF_0000, 1);
    tick;
    check("coin_load_valid", {31'd0, fs_valid}, 32'd1);
    check("coin_load_pc",    fs_pc,   32'h3000_0000);
    check("coin_load_inst",  fs_inst, 32'hFFFF_0000);

    // Two redirects during one outstanding request
    drive(0, 0, 1, 0, 0, 1);
    check("dbl_addr0", ifc.inst_addr, 32'h3000_0004);
    tick;
    drive(1, 32'h4000_0000, 0, 0, 0, 1);
    tick;
    drive(1, 32'h5000_0000, 0, 0, 0, 1);
    tick;
    drive(0, 0, 0, 1, 32'h1111_1111, 1);
    tick;
    check("dbl_drop", {31'd0, fs_valid}, 32'd0);
    drive(0, 0, 1, 0, 0, 1);
    check("dbl_addr", ifc.inst_addr, 32'h5000_0000);
    tick;
    drive(0, 0, 0, 1, 32'h2222_2222, 1);
    tick;
    check("dbl_valid", {31'd0, fs_valid}, 32'd1);
    check("dbl_pc",    fs_pc,   32'h5000_0000);
    check("dbl_inst",  fs_inst, 32'h2222_2222);

    // Address wrap past the top of memory
    drive(1, 32'hFFFF_FFFF, 1, 0, 0, 1);
    tick;
    drive(0, 0, 1, 0, 0, 1);
    check("wrap_addr0", ifc.inst_addr, 32'hFFFF_FFFC);
    tick;
    drive(0, 0, 0, 1, 32'h3333_3333, 1);
    tick;
    drive(0, 0, 1, 0, 0, 1);
    check("wrap_pc",    fs_pc, 32'hFFFF_FFFC);
    check("wrap_addr1", ifc.inst_addr, 32'h0000_0000);
    tick;

    // Asynchronous reset in the middle of a wait
    drive(0, 0, 0, 0, 0, 1);
    resetn = 1'b0;
    #1;
    check("arst_pc",    fs_pc,   32'd0);
    check("arst_inst",  fs_inst, 32'd0);
    check("arst_valid", {31'd0, fs_valid},     32'd0);
    check("arst_req",   {31'd0, ifc.inst_req}, 32'd0);
    drive(0, 0, 0, 1, 32'h4444_4444, 1);
    tick;
    resetn = 1'b1;
    drive(0, 0, 0, 0, 0, 1);
    check("rel_idle_req", {31'd0, ifc.inst_req}, 32'd0);
    check("rel_valid",    {31'd0, fs_valid},     32'd0);
    tick;
    drive(0, 0, 1, 0, 0, 1);
    check("rel_req",  {31'd0, ifc.inst_req}, 32'd1);
    check("rel_addr", ifc.inst_addr, 32'h1c00_0000);
    tick;
    drive(0, 0, 0, 1, 32'h5555_5555, 1);
    tick;
    check("rel_pc",   fs_pc,   32'h1c00_0000);
    check("rel_inst", fs_inst, 32'h5555_5555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
